mbinit_repairclk_module: RTL and testbench

//  - Requester ("Module") side of MBINIT.REPAIRCLK; the partner-side responder answers its requests.
//  - Sequence: send init_req and wait for init_resp. Drive the clock repair pattern for PATTERN_CYCLES.

---
 rtl/mbinit_pkg.sv | 32 +++
 rtl/mbinit_repairclk_module.sv | 156 +++++++++++++++
 tb/tb_mbinit_repairclk_module.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: REPAIRCLK sideband message codes (also used by
// the partner-side responder), the all-pass clock-track result, and the
// requester state encoding.
package mbinit_pkg;

  localparam logic [3:0] REPAIRCLK_INIT_REQ    = 4'd1;
  localparam logic [3:0] REPAIRCLK_INIT_RESP   = 4'd2;
  localparam logic [3:0] REPAIRCLK_RESULT_REQ  = 4'd3;
  localparam logic [3:0] REPAIRCLK_RESULT_RESP = 4'd4;
  localparam logic [3:0] REPAIRCLK_DONE_REQ    = 4'd5;
  localparam logic [3:0] REPAIRCLK_DONE_RESP   = 4'd6;

  // {RTRK,RCKN,RCKP} all passing
  localparam logic [2:0] REPAIRCLK_ALL_PASS = 3'b111;

  typedef enum logic [3:0] {
    RC_IDLE             = 4'd0,
    RC_WAIT_BUSY_INIT   = 4'd1,
    RC_SEND_INIT_REQ    = 4'd2,
    RC_WAIT_INIT_RESP   = 4'd3,
    RC_SEND_PATTERN     = 4'd4,
    RC_WAIT_BUSY_RESULT = 4'd5,
    RC_SEND_RESULT_REQ  = 4'd6,
    RC_WAIT_RESULT_RESP = 4'd7,
    RC_WAIT_BUSY_DONE   = 4'd8,
    RC_SEND_DONE_REQ    = 4'd9,
    RC_WAIT_DONE_RESP   = 4'd10,
    RC_DONE             = 4'd11,
    RC_ERROR            = 4'd12
  } repairclk_state_e;

endpackage

// File: rtl/mbinit_repairclk_module.sv
// MBINIT.REPAIRCLK requester: init handshake, clock repair pattern burst,
// result query and done handshake; flags success or lane failure.
// Optional watchdog: define MBINIT_REPAIRCLK_TIMEOUT_EN.
// Ports:
//   CLK, rst_n (sync, active-low)
//   i_MBINIT_CAL_end              enable level; low aborts to IDLE
//   i_RX_SbMessage/i_msg_valid    received sideband message
//   i_Clock_track_result_logged   {RTRK,RCKN,RCKP} pass bits with result_resp
//   i_Busy_SideBand               sideband TX busy
//   i_falling_edge_busy           sideband finished sending (pulse)
//   o_TX_SbMessage/o_ValidOutDatat_Module  TX request
//   o_clk_pattern_en              clock repair pattern enable
//   o_Clock_track_result_logged   captured result, held until IDLE
//   o_MBINIT_REPAIRCLK_Module_end success level
//   o_train_error                 failure level
module mbinit_repairclk_module
  import mbinit_pkg::*;
#(
  parameter int unsigned PATTERN_CYCLES = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_CAL_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_Clock_track_result_logged,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_clk_pattern_en,
  output logic [2:0] o_Clock_track_result_logged,
  output logic       o_MBINIT_REPAIRCLK_Module_end,
  output logic       o_train_error
);

  localparam int unsigned PCW = (PATTERN_CYCLES > 1) ? $clog2(PATTERN_CYCLES) : 1;
  localparam logic [PCW-1:0] PAT_LAST = PCW'(PATTERN_CYCLES - 1);

  repairclk_state_e r_state, w_next_state;
  logic [PCW-1:0]   r_pat_cnt;
  logic             w_result_cap;
  logic [3:0]       w_tx;
  logic             w_valid, w_pat_en, w_end, w_err;

`ifdef MBINIT_REPAIRCLK_TIMEOUT_EN
  localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] r_wd;
  logic           w_wd_active;
  assign w_wd_active = (r_state != RC_IDLE) && (r_state != RC_DONE) && (r_state != RC_ERROR);
`endif

  // Next-state logic; priority is abort > timeout > message events
  always_comb begin
    w_next_state = r_state;
    w_result_cap = 1'b0;
    unique case (r_state)
      RC_IDLE:             if (i_MBINIT_CAL_end) w_next_state = RC_WAIT_BUSY_INIT;
      RC_WAIT_BUSY_INIT:   if (!i_Busy_SideBand) w_next_state = RC_SEND_INIT_REQ;
      RC_SEND_INIT_REQ:    if (i_falling_edge_busy) w_next_state = RC_WAIT_INIT_RESP;
      RC_WAIT_INIT_RESP:
        if (i_msg_valid && (i_RX_SbMessage == REPAIRCLK_INIT_RESP))
          w_next_state = RC_SEND_PATTERN;
      RC_SEND_PATTERN:     if (r_pat_cnt == PAT_LAST) w_next_state = RC_WAIT_BUSY_RESULT;
      RC_WAIT_BUSY_RESULT: if (!i_Busy_SideBand) w_next_state = RC_SEND_RESULT_REQ;
      RC_SEND_RESULT_REQ:  if (i_falling_edge_busy) w_next_state = RC_WAIT_RESULT_RESP;
      RC_WAIT_RESULT_RESP:
        if (i_msg_valid && (i_RX_SbMessage == REPAIRCLK_RESULT_RESP)) begin
          w_result_cap = 1'b1;
          w_next_state = (i_Clock_track_result_logged == REPAIRCLK_ALL_PASS) ?
                         RC_WAIT_BUSY_DONE : RC_ERROR;
        end
      RC_WAIT_BUSY_DONE:   if (!i_Busy_SideBand) w_next_state = RC_SEND_DONE_REQ;
      RC_SEND_DONE_REQ:    if (i_falling_edge_busy) w_next_state = RC_WAIT_DONE_RESP;
      RC_WAIT_DONE_RESP:
        if (i_msg_valid && (i_RX_SbMessage == REPAIRCLK_DONE_RESP))
          w_next_state = RC_DONE;
      RC_DONE:             w_next_state = RC_DONE;
      RC_ERROR:            w_next_state = RC_ERROR;
      default:             w_next_state = RC_IDLE;
    endcase
`ifdef MBINIT_REPAIRCLK_TIMEOUT_EN
    if (w_wd_active && (r_wd == WD_LAST)) begin
      w_next_state = RC_ERROR;
      w_result_cap = 1'b0;
    end
`endif
    if (!i_MBINIT_CAL_end) begin
      w_next_state = RC_IDLE;
      w_result_cap = 1'b0;
    end
  end

  // Output decode from the next state so outputs align with state entry
  always_comb begin
    w_tx     = 4'd0;
    w_valid  = 1'b0;
    w_pat_en = 1'b0;
    w_end    = 1'b0;
    w_err    = 1'b0;
    case (w_next_state)
      RC_SEND_INIT_REQ:   begin w_tx = REPAIRCLK_INIT_REQ;   w_valid = 1'b1; end
      RC_SEND_RESULT_REQ: begin w_tx = REPAIRCLK_RESULT_REQ; w_valid = 1'b1; end
      RC_SEND_DONE_REQ:   begin w_tx = REPAIRCLK_DONE_REQ;   w_valid = 1'b1; end
      RC_SEND_PATTERN:    w_pat_en = 1'b1;
      RC_DONE:            w_end    = 1'b1;
      RC_ERROR:           w_err    = 1'b1;
      default:            ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state                       <= RC_IDLE;
      r_pat_cnt                     <= '0;
      o_TX_SbMessage                <= 4'd0;
      o_ValidOutDatat_Module        <= 1'b0;
      o_clk_pattern_en              <= 1'b0;
      o_Clock_track_result_logged   <= 3'b000;
      o_MBINIT_REPAIRCLK_Module_end <= 1'b0;
      o_train_error                 <= 1'b0;
    end else begin
      r_state                       <= w_next_state;
      o_TX_SbMessage                <= w_tx;
      o_ValidOutDatat_Module        <= w_valid;
      o_clk_pattern_en              <= w_pat_en;
      o_MBINIT_REPAIRCLK_Module_end <= w_end;
      o_train_error                 <= w_err;
      // counter is zero on every entry to SEND_PATTERN
      if ((r_state == RC_SEND_PATTERN) && (w_next_state == RC_SEND_PATTERN))
        r_pat_cnt <= r_pat_cnt + PCW'(1);
      else
        r_pat_cnt <= '0;
      if (w_next_state == RC_IDLE)
        o_Clock_track_result_logged <= 3'b000;
      else if (w_result_cap)
        o_Clock_track_result_logged <= i_Clock_track_result_logged;
    end
  end

`ifdef MBINIT_REPAIRCLK_TIMEOUT_EN
  // Watchdog spans the whole sequence from leaving IDLE
  always_ff @(posedge CLK) begin
    if (!rst_n)
      r_wd <= '0;
    else if ((r_state == RC_IDLE) || (w_next_state == RC_IDLE))
      r_wd <= '0;
    else if (w_wd_active)
      r_wd <= r_wd + WDW'(1);
  end
`endif

endmodule

// File: tb/tb_mbinit_repairclk_module.sv
module tb_mbinit_repairclk_module;

  localparam int unsigned P = 128;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       cal_end;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic [2:0] rx_result;
  logic       busy;
  logic       fe_busy;
  logic [3:0] tx_msg;
  logic       tx_valid;
  logic       pat_en;
  logic [2:0] result;
  logic       mod_end;
  logic       train_err;

  always #5 CLK = ~CLK;

  mbinit_repairclk_module #(.PATTERN_CYCLES(P), .TIMEOUT_CYCLES(200)) dut (
    .CLK                           (CLK),
    .rst_n                         (rst_n),
    .i_MBINIT_CAL_end              (cal_end),
    .i_RX_SbMessage                (rx_msg),
    .i_msg_valid                   (msg_valid),
    .i_Clock_track_result_logged   (rx_result),
    .i_Busy_SideBand               (busy),
    .i_falling_edge_busy           (fe_busy),
    .o_TX_SbMessage                (tx_msg),
    .o_ValidOutDatat_Module        (tx_valid),
    .o_clk_pattern_en              (pat_en),
    .o_Clock_track_result_logged   (result),
    .o_MBINIT_REPAIRCLK_Module_end (mod_end),
    .o_train_error                 (train_err)
  );

  // Observable events: TX request (code), pattern burst (length), success, failure (result)
  localparam logic [1:0] EV_TX = 2'd0, EV_PAT = 2'd1, EV_END = 2'd2, EV_ERR = 2'd3;
  typedef struct packed { logic [1:0] kind; logic [15:0] val; } ev_t;
  ev_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = 16'(v);
    exp_q.push_back(e);
  endtask

  // Reference model: the event trace a complete sequence produces for a given result
  task automatic model_seq(input logic [2:0] res);
    push_ev(EV_TX, 1);
    push_ev(EV_PAT, P);
    push_ev(EV_TX, 3);
    if (res == 3'b111) begin
      push_ev(EV_TX, 5);
      push_ev(EV_END, 0);
    end else begin
      push_ev(EV_ERR, int'(res));
    end
  endtask

  task automatic got_ev(input logic [1:0] k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", 32'(k), 32'hFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_value", 32'(v), 32'(e.val));
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them
  logic pv, ppat, pend, perr;
  int   pat_len;
  always @(negedge CLK) begin
    if (!rst_n) begin
      pv = 1'b0; ppat = 1'b0; pend = 1'b0; perr = 1'b0; pat_len = 0;
    end else begin
      if (tx_valid && !pv) got_ev(EV_TX, int'(tx_msg));
      if (pat_en) pat_len++;
      else if (ppat) begin
        got_ev(EV_PAT, pat_len);
        pat_len = 0;
      end
      if (mod_end && !pend) got_ev(EV_END, 0);
      if (train_err && !perr) got_ev(EV_ERR, int'(result));
      pv = tx_valid; ppat = pat_en; pend = mod_end; perr = train_err;
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return tx_valid;
      1: return pat_en;
      2: return mod_end;
      default: return train_err;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic lvl, input int limit, input string name);
    int n;
    n = 0;
    while (sig(w) !== lvl && n < limit) begin
      tick();
      n++;
    end
    if (sig(w) !== lvl) check(name, 32'(sig(w)), 32'(lvl));
  endtask

  task automatic send_msg(input logic [3:0] code, input logic [2:0] res, input logic mv);
    rx_msg = code; rx_result = res; msg_valid = mv;
    tick();
    rx_msg = 4'd0; rx_result = 3'd0; msg_valid = 1'b0;
  endtask

  // Wait for a TX request, hold it, then complete it with a falling-edge pulse
  task automatic tx_handshake(input int hold);
    wait_sig(0, 1'b1, 50, "tx_valid_timeout");
    for (int i = 0; i < hold; i++) begin
      tick();
      check("valid_held", 32'(tx_valid), 32'd1);
    end
    fe_busy = 1'b1;
    tick();
    fe_busy = 1'b0;
    check("valid_drop_after_fe", 32'(tx_valid), 32'd0);
  endtask

  task automatic delay_rand();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic abort_and_check();
    cal_end = 1'b0;
    tick();
    check("outputs_clear_on_abort",
          32'({tx_msg, tx_valid, pat_en, result, mod_end, train_err}), 32'd0);
  endtask

  task automatic run_seq(input logic [2:0] res, input bit noise, input bit busy_hold);
    int bad;
    model_seq(res);
    if (busy_hold) begin
      busy = 1'b1;
      cal_end = 1'b1;
      bad = 0;
      repeat (10) begin
        tick();
        if (tx_valid !== 1'b0) bad++;
      end
      check("no_valid_while_busy", 32'(bad), 32'd0);
      busy = 1'b0;
      tick();
      check("valid_after_busy_drop", 32'(tx_valid), 32'd1);
      tx_handshake(4);
    end else begin
      cal_end = 1'b1;
      tx_handshake($urandom_range(0, 2));
    end
    delay_rand();
    if (noise) begin
      send_msg(4'd4, 3'b010, 1'b1);
      send_msg(4'd2, 3'b000, 1'b0);
      tick();
      check("noise_ignored", 32'({pat_en, tx_valid, train_err}), 32'd0);
    end
    send_msg(4'd2, 3'd0, 1'b1);
    wait_sig(1, 1'b1, 10, "pattern_start_timeout");
    wait_sig(1, 1'b0, P + 10, "pattern_end_timeout");
    tx_handshake($urandom_range(0, 2));
    delay_rand();
    send_msg(4'd4, res, 1'b1);
    if (res == 3'b111) begin
      tx_handshake($urandom_range(0, 2));
      delay_rand();
      send_msg(4'd6, 3'd0, 1'b1);
      wait_sig(2, 1'b1, 10, "module_end_timeout");
      repeat (5) tick();
      check("module_end_held", 32'({mod_end, train_err, result}), 32'({1'b1, 1'b0, 3'b111}));
    end else begin
      wait_sig(3, 1'b1, 10, "train_error_timeout");
      check("fail_result_logged", 32'(result), 32'(res));
      bad = 0;
      repeat (20) begin
        tick();
        if (tx_valid !== 1'b0 || train_err !== 1'b1) bad++;
      end
      check("no_done_req_after_fail", 32'(bad), 32'd0);
    end
    abort_and_check();
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    logic [2:0] r;
    rst_n = 1'b0; cal_end = 1'b1; rx_msg = 4'd0; msg_valid = 1'b0;
    rx_result = 3'd0; busy = 1'b0; fe_busy = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({tx_msg, tx_valid, pat_en, result, mod_end, train_err}), 32'd0);
    cal_end = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    run_seq(3'b111, 1'b0, 1'b0);
    run_seq(3'b101, 1'b0, 1'b0);
    run_seq(3'b111, 1'b0, 1'b1);
    run_seq(3'b111, 1'b1, 1'b0);

    // abort at pattern cycle 50, then a full fresh run
    push_ev(EV_TX, 1);
    push_ev(EV_PAT, 50);
    cal_end = 1'b1;
    tx_handshake(1);
    send_msg(4'd2, 3'd0, 1'b1);
    wait_sig(1, 1'b1, 10, "abort_pattern_start_timeout");
    repeat (49) tick();
    abort_and_check();
    run_seq(3'b111, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 6));
      run_seq(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // stall: init_resp never arrives
    push_ev(EV_TX, 1);
`ifdef MBINIT_REPAIRCLK_TIMEOUT_EN
    push_ev(EV_ERR, 0);
    cal_end = 1'b1;
    n = 0;
    while (train_err !== 1'b1 && n < 300) begin
      if (tx_valid === 1'b1) begin
        fe_busy = 1'b1;
        tick();
        fe_busy = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    check("timeout_window", 32'((n >= 195) && (n <= 205)), 32'd1);
`else
    cal_end = 1'b1;
    tx_handshake(0);
    n = 0;
    repeat (10000) begin
      tick();
      if (train_err !== 1'b0 || pat_en !== 1'b0) n++;
    end
    check("stall_no_error", 32'(n), 32'd0);
`endif
    abort_and_check();

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
